// File: rtl/instr_seq_ctrl_if.sv
// Command port of the instruction sequencer: a valid/ready programming bus
// carrying a register/RAM select, an address or register index, and write data.
interface instr_seq_ctrl_if #(
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned DATA_W = 4
) ();
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_sel;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_data;

    // Command source drives the request and payload
    modport master (
        output cmd_valid,
        output cmd_sel,
        output cmd_addr,
        output cmd_data,
        input  cmd_ready
    );

    // Sequencer accepts the request
    modport slave (
        input  cmd_valid,
        input  cmd_sel,
        input  cmd_addr,
        input  cmd_data,
        output cmd_ready
    );
endinterface

// File: rtl/instr_seq_ctrl.sv
// Instruction-fetch sequencer: arbitrates the programming port between the
// prescaler config register, the program-length register and the instruction
// RAM, then steps the read address on prescaler ticks up to the last address.
// Optional macro INSTR_SEQ_LOOP_EN: wrap to address 0 at the last address and
// keep running, pulsing done as a wrap indicator instead of entering DONE.
module instr_seq_ctrl #(
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned DATA_W = 4,
    parameter int unsigned CFG_W  = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    instr_seq_ctrl_if.slave    cmd,
    input  logic               run,
    input  logic               tick,
    output logic               cfg_we,
    output logic [CFG_W-1:0]   cfg_wdata,
    output logic               ram_we,
    output logic [ADDR_W-1:0]  ram_waddr,
    output logic [DATA_W-1:0]  ram_wdata,
    output logic [ADDR_W-1:0]  rd_addr,
    output logic               busy,
    output logic               done
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_RUN   = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    localparam logic [ADDR_W-1:0] REG_CFG = ADDR_W'(0);
    localparam logic [ADDR_W-1:0] REG_LEN = ADDR_W'(1);

    state_e              state_q,     state_d;
    logic                cmd_ready_q, cmd_ready_d;
    logic                cfg_we_q,    cfg_we_d;
    logic [CFG_W-1:0]    cfg_wdata_q, cfg_wdata_d;
    logic                ram_we_q,    ram_we_d;
    logic [ADDR_W-1:0]   ram_waddr_q, ram_waddr_d;
    logic [DATA_W-1:0]   ram_wdata_q, ram_wdata_d;
    logic [ADDR_W-1:0]   rd_addr_q,   rd_addr_d;
    logic [ADDR_W-1:0]   last_addr_q, last_addr_d;
    logic                busy_q,      busy_d;
    logic                done_q,      done_d;
    logic                at_last;

    assign at_last = (rd_addr_q == last_addr_q);

    // State and registered-output flops with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cmd_ready_q <= 1'b0;
            cfg_we_q    <= 1'b0;
            cfg_wdata_q <= '0;
            ram_we_q    <= 1'b0;
            ram_waddr_q <= '0;
            ram_wdata_q <= '0;
            rd_addr_q   <= '0;
            last_addr_q <= '1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cmd_ready_q <= cmd_ready_d;
            cfg_we_q    <= cfg_we_d;
            cfg_wdata_q <= cfg_wdata_d;
            ram_we_q    <= ram_we_d;
            ram_waddr_q <= ram_waddr_d;
            ram_wdata_q <= ram_wdata_d;
            rd_addr_q   <= rd_addr_d;
            last_addr_q <= last_addr_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    // Next-state: commands win over run in IDLE; run=0 wins over tick in RUN.
    // IDLE acts only once cmd_ready is up, so nothing happens in the first
    // cycle after reset release.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (cmd_ready_q) begin
                    if (cmd.cmd_valid) begin
                        state_d = S_WRITE;
                    end else if (run) begin
                        state_d = S_RUN;
                    end
                end
            end
            S_WRITE: state_d = S_IDLE;
            S_RUN: begin
                if (!run) begin
                    state_d = S_IDLE;
                end else if (tick && at_last) begin
`ifdef INSTR_SEQ_LOOP_EN
                    state_d = S_RUN;
`else
                    state_d = S_DONE;
`endif
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs: write strobes are registered at command acceptance so they
    // appear during the single WRITE cycle; status follows the next state.
    always_comb begin
        cmd_ready_d = (state_d == S_IDLE);
        busy_d      = (state_d == S_RUN);
        done_d      = 1'b0;
        cfg_we_d    = 1'b0;
        ram_we_d    = 1'b0;
        cfg_wdata_d = cfg_wdata_q;
        ram_waddr_d = ram_waddr_q;
        ram_wdata_d = ram_wdata_q;
        rd_addr_d   = rd_addr_q;
        last_addr_d = last_addr_q;
        case (state_q)
            S_IDLE: begin
                if (state_d == S_WRITE) begin
                    if (cmd.cmd_sel) begin
                        ram_we_d    = 1'b1;
                        ram_waddr_d = cmd.cmd_addr;
                        ram_wdata_d = cmd.cmd_data;
                    end else if (cmd.cmd_addr == REG_CFG) begin
                        cfg_we_d    = 1'b1;
                        cfg_wdata_d = cmd.cmd_data[CFG_W-1:0];
                    end else if (cmd.cmd_addr == REG_LEN) begin
                        last_addr_d = cmd.cmd_data[ADDR_W-1:0];
                    end
                end else if (state_d == S_RUN) begin
                    rd_addr_d = '0;
                end
            end
            S_RUN: begin
                if (run && tick) begin
                    if (at_last) begin
                        done_d = 1'b1;
`ifdef INSTR_SEQ_LOOP_EN
                        rd_addr_d = '0;
`endif
                    end else begin
                        rd_addr_d = rd_addr_q + ADDR_W'(1);
                    end
                end
            end
            default: ;
        endcase
    end

    assign cmd.cmd_ready = cmd_ready_q;
    assign cfg_we        = cfg_we_q;
    assign cfg_wdata     = cfg_wdata_q;
    assign ram_we        = ram_we_q;
    assign ram_waddr     = ram_waddr_q;
    assign ram_wdata     = ram_wdata_q;
    assign rd_addr       = rd_addr_q;
    assign busy          = busy_q;
    assign done          = done_q;

endmodule

// File: tb/tb_instr_seq_ctrl.sv
// Self-checking bench for instr_seq_ctrl: write strobes are checked by a
// scoreboard monitor, sequencing behaviour by per-scenario tasks.
module tb_instr_seq_ctrl;

    localparam int unsigned ADDR_W = 4;
    localparam int unsigned DATA_W = 4;
    localparam int unsigned CFG_W  = 4;
`ifdef INSTR_SEQ_LOOP_EN
    localparam logic LOOP = 1'b1;
`else
    localparam logic LOOP = 1'b0;
`endif

    logic              clk   = 1'b0;
    logic              rst_n = 1'b0;
    logic              run   = 1'b0;
    logic              tick  = 1'b0;
    logic              cfg_we;
    logic [CFG_W-1:0]  cfg_wdata;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_waddr;
    logic [DATA_W-1:0] ram_wdata;
    logic [ADDR_W-1:0] rd_addr;
    logic              busy;
    logic              done;

    instr_seq_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) cmd_if ();

    instr_seq_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CFG_W(CFG_W)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd       (cmd_if.slave),
        .run       (run),
        .tick      (tick),
        .cfg_we    (cfg_we),
        .cfg_wdata (cfg_wdata),
        .ram_we    (ram_we),
        .ram_waddr (ram_waddr),
        .ram_wdata (ram_wdata),
        .rd_addr   (rd_addr),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        is_ram;
        logic [3:0]  addr;
        logic [3:0]  data;
    } wr_t;

    wr_t exp_q[$];
    int  checks = 0;
    int  passed = 0;

    // Scoreboard: every strobe must match the oldest expected write
    always @(posedge clk) begin
        wr_t e;
        #1;
        if (ram_we === 1'b1 || cfg_we === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL strobe_unexpected: got ram_we=%b cfg_we=%b, expected no strobe", ram_we, cfg_we);
            end else begin
                e = exp_q.pop_front();
                if ({ram_we, cfg_we, (ram_we ? ram_waddr : 4'd0), (ram_we ? ram_wdata : cfg_wdata)}
                    !== {e.is_ram, ~e.is_ram, (e.is_ram ? e.addr : 4'd0), e.data})
                    $display("FAIL strobe: got ram_we=%b cfg_we=%b waddr=%h wdata=%h cfg=%h, expected ram=%b addr=%h data=%h",
                             ram_we, cfg_we, ram_waddr, ram_wdata, cfg_wdata, e.is_ram, e.addr, e.data);
                else
                    passed++;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic sel, input logic [3:0] addr, input logic [3:0] data);
        wr_t e;
        e.is_ram = sel;
        e.addr   = addr;
        e.data   = data;
        exp_q.push_back(e);
    endtask

    task automatic send_cmd(input logic sel, input logic [3:0] addr, input logic [3:0] data);
        int waited = 0;
        while (cmd_if.cmd_ready !== 1'b1 && waited < 20) begin
            step();
            waited++;
        end
        checks++;
        if (cmd_if.cmd_ready !== 1'b1) $display("FAIL cmd_wait: cmd_ready=%b, expected 1 within 20 cycles", cmd_if.cmd_ready);
        else passed++;
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_sel   = sel;
        cmd_if.cmd_addr  = addr;
        cmd_if.cmd_data  = data;
        if (sel || addr == 4'd0) push_exp(sel, addr, data);
        step();
        cmd_if.cmd_valid = 1'b0;
        checks++;
        if ({cmd_if.cmd_ready, busy} !== 2'b00) $display("FAIL write_state: ready,busy=%b, expected 00", {cmd_if.cmd_ready, busy});
        else passed++;
        step();
        checks++;
        if (cmd_if.cmd_ready !== 1'b1) $display("FAIL write_return: cmd_ready=%b, expected 1", cmd_if.cmd_ready);
        else passed++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        step();
        checks++;
        if ({cmd_if.cmd_ready, cfg_we, ram_we, cfg_wdata, ram_waddr, ram_wdata, rd_addr, busy, done} !== '0)
            $display("FAIL reset_outputs: got ready=%b cfg_we=%b ram_we=%b cfg=%h wa=%h wd=%h rd=%h busy=%b done=%b, expected all 0",
                     cmd_if.cmd_ready, cfg_we, ram_we, cfg_wdata, ram_waddr, ram_wdata, rd_addr, busy, done);
        else passed++;
        rst_n = 1'b1;
        step();
        checks++;
        if ({cmd_if.cmd_ready, busy, done, rd_addr} !== {1'b1, 1'b0, 1'b0, 4'd0})
            $display("FAIL reset_release: ready,busy,done,rd=%b_%b_%b_%h, expected 1_0_0_0", cmd_if.cmd_ready, busy, done, rd_addr);
        else passed++;
    endtask

    // Program length after reset is all-ones: 15 increments, done on the 16th tick
    task automatic test_default_len();
        run = 1'b1;
        step();
        for (int i = 1; i <= 16; i++) begin
            tick = 1'b1;
            step();
            tick = 1'b0;
            checks++;
            if (i < 16) begin
                if ({busy, rd_addr, done} !== {1'b1, 4'(i), 1'b0})
                    $display("FAIL default_len_step: busy,rd,done=%b_%h_%b, expected 1_%h_0", busy, rd_addr, done, 4'(i));
                else passed++;
            end else begin
                if ({busy, rd_addr, done} !== {LOOP, (LOOP ? 4'd0 : 4'd15), 1'b1})
                    $display("FAIL default_len_end: busy,rd,done=%b_%h_%b, expected %b_%h_1", busy, rd_addr, done, LOOP, (LOOP ? 4'd0 : 4'd15));
                else passed++;
            end
        end
        run = 1'b0;
        step();
        checks++;
        if ({busy, done, cmd_if.cmd_ready} !== 3'b001) $display("FAIL default_len_idle: busy,done,ready=%b, expected 001", {busy, done, cmd_if.cmd_ready});
        else passed++;
    endtask

    task automatic test_ram_load();
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_sel   = 1'b1;
        cmd_if.cmd_addr  = 4'd5;
        cmd_if.cmd_data  = 4'hA;
        push_exp(1'b1, 4'd5, 4'hA);
        step();
        cmd_if.cmd_valid = 1'b0;
        checks++;
        if ({ram_we, ram_waddr, ram_wdata, cmd_if.cmd_ready} !== {1'b1, 4'd5, 4'hA, 1'b0})
            $display("FAIL ram_load: we,addr,data,ready=%b_%h_%h_%b, expected 1_5_a_0", ram_we, ram_waddr, ram_wdata, cmd_if.cmd_ready);
        else passed++;
        step();
        checks++;
        if ({ram_we, cmd_if.cmd_ready} !== 2'b01) $display("FAIL ram_load_after: we,ready=%b, expected 01", {ram_we, cmd_if.cmd_ready});
        else passed++;
        // Held valid: accepted on every other cycle
        for (int k = 0; k < 6; k++) begin
            cmd_if.cmd_valid = 1'b1;
            cmd_if.cmd_sel   = 1'b1;
            cmd_if.cmd_addr  = 4'(k + 8);
            cmd_if.cmd_data  = 4'(15 - k);
            if (k % 2 == 0) push_exp(1'b1, 4'(k + 8), 4'(15 - k));
            step();
            checks++;
            if (cmd_if.cmd_ready !== ((k % 2) == 1)) $display("FAIL back_to_back_ready: k=%0d ready=%b, expected %b", k, cmd_if.cmd_ready, ((k % 2) == 1));
            else passed++;
        end
        cmd_if.cmd_valid = 1'b0;
        step();
    endtask

    task automatic test_cfg_len();
        send_cmd(1'b0, 4'd0, 4'd3);
        checks++;
        if ({cfg_we, cfg_wdata} !== {1'b0, 4'd3}) $display("FAIL cfg_hold: cfg_we,cfg_wdata=%b_%h, expected 0_3", cfg_we, cfg_wdata);
        else passed++;
        send_cmd(1'b0, 4'd7, 4'd9);
        send_cmd(1'b0, 4'd1, 4'd2);
        run = 1'b1;
        step();
        checks++;
        if ({busy, rd_addr, cmd_if.cmd_ready} !== {1'b1, 4'd0, 1'b0}) $display("FAIL run_entry: busy,rd,ready=%b_%h_%b, expected 1_0_0", busy, rd_addr, cmd_if.cmd_ready);
        else passed++;
        for (int t = 1; t <= 3; t++) begin
            for (int c = 0; c < 3; c++) begin
                step();
                checks++;
                if ({busy, rd_addr, done} !== {1'b1, 4'(t - 1), 1'b0}) $display("FAIL run_wait: busy,rd,done=%b_%h_%b, expected 1_%h_0", busy, rd_addr, done, 4'(t - 1));
                else passed++;
            end
            tick = 1'b1;
            step();
            tick = 1'b0;
            checks++;
            if (t < 3) begin
                if ({busy, rd_addr, done} !== {1'b1, 4'(t), 1'b0}) $display("FAIL run_tick: busy,rd,done=%b_%h_%b, expected 1_%h_0", busy, rd_addr, done, 4'(t));
                else passed++;
            end else begin
                if ({busy, rd_addr, done} !== {LOOP, (LOOP ? 4'd0 : 4'd2), 1'b1})
                    $display("FAIL run_done: busy,rd,done=%b_%h_%b, expected %b_%h_1", busy, rd_addr, done, LOOP, (LOOP ? 4'd0 : 4'd2));
                else passed++;
            end
        end
        run = 1'b0;
        step();
        checks++;
        if ({busy, done, cmd_if.cmd_ready} !== 3'b001) $display("FAIL done_return: busy,done,ready=%b, expected 001", {busy, done, cmd_if.cmd_ready});
        else passed++;
    endtask

    task automatic test_arbitration();
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_sel   = 1'b1;
        cmd_if.cmd_addr  = 4'd3;
        cmd_if.cmd_data  = 4'd6;
        run = 1'b1;
        push_exp(1'b1, 4'd3, 4'd6);
        step();
        cmd_if.cmd_valid = 1'b0;
        checks++;
        if ({ram_we, busy, cmd_if.cmd_ready} !== 3'b100) $display("FAIL arb_write_first: we,busy,ready=%b, expected 100", {ram_we, busy, cmd_if.cmd_ready});
        else passed++;
        step();
        step();
        checks++;
        if ({busy, rd_addr} !== {1'b1, 4'd0}) $display("FAIL arb_run_second: busy,rd=%b_%h, expected 1_0", busy, rd_addr);
        else passed++;
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_sel   = 1'b1;
        cmd_if.cmd_addr  = 4'd12;
        cmd_if.cmd_data  = 4'd1;
        for (int c = 0; c < 3; c++) begin
            step();
            checks++;
            if ({cmd_if.cmd_ready, busy} !== 2'b01) $display("FAIL run_holdoff: ready,busy=%b, expected 01", {cmd_if.cmd_ready, busy});
            else passed++;
        end
        run = 1'b0;
        step();
        checks++;
        if ({cmd_if.cmd_ready, busy} !== 2'b10) $display("FAIL holdoff_release: ready,busy=%b, expected 10", {cmd_if.cmd_ready, busy});
        else passed++;
        push_exp(1'b1, 4'd12, 4'd1);
        step();
        cmd_if.cmd_valid = 1'b0;
        step();
    endtask

    task automatic test_abort();
        send_cmd(1'b0, 4'd1, 4'd5);
        run = 1'b1;
        step();
        for (int i = 0; i < 3; i++) begin
            tick = 1'b1;
            step();
        end
        tick = 1'b0;
        checks++;
        if ({busy, rd_addr} !== {1'b1, 4'd3}) $display("FAIL abort_setup: busy,rd=%b_%h, expected 1_3", busy, rd_addr);
        else passed++;
        run  = 1'b0;
        tick = 1'b1;
        step();
        tick = 1'b0;
        checks++;
        if ({busy, rd_addr, done, cmd_if.cmd_ready} !== {1'b0, 4'd3, 1'b0, 1'b1})
            $display("FAIL abort_run_drop: busy,rd,done,ready=%b_%h_%b_%b, expected 0_3_0_1", busy, rd_addr, done, cmd_if.cmd_ready);
        else passed++;
        run = 1'b1;
        step();
        checks++;
        if ({busy, rd_addr} !== {1'b1, 4'd0}) $display("FAIL rerun_restart: busy,rd=%b_%h, expected 1_0", busy, rd_addr);
        else passed++;
        tick = 1'b1;
        step();
        tick  = 1'b0;
        rst_n = 1'b0;
        step();
        checks++;
        if ({rd_addr, busy, done, cmd_if.cmd_ready} !== '0)
            $display("FAIL abort_reset: rd,busy,done,ready=%h_%b_%b_%b, expected 0_0_0_0", rd_addr, busy, done, cmd_if.cmd_ready);
        else passed++;
        rst_n = 1'b1;
        run   = 1'b0;
        step();
    endtask

    task automatic test_last_zero();
        send_cmd(1'b0, 4'd1, 4'd0);
        run = 1'b1;
        step();
        tick = 1'b1;
        step();
        tick = 1'b0;
        checks++;
        if ({busy, rd_addr, done} !== {LOOP, 4'd0, 1'b1}) $display("FAIL last_zero_done: busy,rd,done=%b_%h_%b, expected %b_0_1", busy, rd_addr, done, LOOP);
        else passed++;
        step();
        checks++;
        if ({busy, done, cmd_if.cmd_ready} !== {LOOP, 1'b0, ~LOOP}) $display("FAIL last_zero_idle: busy,done,ready=%b, expected %b0%b", {busy, done, cmd_if.cmd_ready}, LOOP, ~LOOP);
        else passed++;
        step();
        checks++;
        if ({busy, cmd_if.cmd_ready, rd_addr} !== {1'b1, 1'b0, 4'd0}) $display("FAIL last_zero_reenter: busy,ready,rd=%b_%b_%h, expected 1_0_0", busy, cmd_if.cmd_ready, rd_addr);
        else passed++;
        run = 1'b0;
        step();
    endtask

    initial begin
        cmd_if.cmd_valid = 1'b0;
        cmd_if.cmd_sel   = 1'b0;
        cmd_if.cmd_addr  = '0;
        cmd_if.cmd_data  = '0;
        test_reset();
        test_default_len();
        test_ram_load();
        test_cfg_len();
        test_arbitration();
        test_abort();
        test_last_zero();
        step();
        checks++;
        if (exp_q.size() != 0) $display("FAIL strobes_missing: %0d expected writes never seen, expected 0", exp_q.size());
        else passed++;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
